// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants, FSM state encoding and frame-building helper for the
// SPI register-access master.
//   ADDR_W / DATA_W / FRAME_BITS : field and frame widths (7 + 1 + 8 = 16)
//   RW_READ / RW_WRITE           : value of the rw bit on the wire
//   state_e                      : master FSM states
//   build_frame()                : assembles the 16-bit MSB-first frame
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Bit counter must hold 0..FRAME_BITS inclusive without wrapping.
  localparam int BIT_CNT_W = 5;

  // Number of falls before the first data bit; miso is captured on the
  // falls that follow (bits 9..16 of the frame).
  localparam int RX_FIRST_FALL = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_TRAIL = 2'd3
  } state_e;

  // Frame layout: addr[6:0], rw, then data. Reads send zeros in the data slot.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] data_field;
    data_field = (rw == RW_READ) ? {DATA_W{1'b0}} : wdata;
    return {addr, rw, data_field};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen
// Half-period tick generator for the SPI serial clock.
//   clk   : system clock
//   reset : synchronous active-high reset (counter to 0)
//   en    : count while high
//   clr   : synchronous clear, overrides en
//   tick  : high for one clk cycle every HALF_DIV enabled cycles; the first
//           tick comes HALF_DIV cycles after the counter leaves clear
// -----------------------------------------------------------------------------
module spi_sclk_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(HALF_DIV) + 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick is combinational on the count so the master can act on the same
  // edge the counter wraps; the master registers everything it drives out.
  assign tick = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// Mode-0 SPI master issuing one 16-bit register access per start request:
// 7-bit address, rw bit, 8 data bits, MSB first.
//   clk      : system clock, all state changes on its rising edge
//   reset    : synchronous active-high reset, wins over start
//   start    : one-cycle frame request, only looked at in IDLE
//   rw       : 1 = read, 0 = write (captured with start)
//   addr     : 7-bit register address (captured with start)
//   wdata    : write data (captured with start, unused for reads)
//   busy     : high from start-accept edge until the done edge
//   done     : one-cycle pulse at frame end
//   rdata    : result of the last completed read
//   sclk_pin : serial clock, idles low
//   cs_pin   : chip select, active low
//   mosi_pin : serial data out
//   miso_pin : serial data in
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk_pin,
  output logic              cs_pin,
  output logic              mosi_pin,
  input  logic              miso_pin
);

  state_e                  state_q, state_d;
  logic                    sclk_q, sclk_d;
  logic                    cs_q, cs_d;
  logic                    mosi_q, mosi_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    rw_q, rw_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]       rx_q, rx_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;

  logic                    tick;
  logic                    div_en;
  logic                    div_clr;
  logic [FRAME_BITS-1:0]   frame;

  // Divider runs for the whole frame and is held cleared in IDLE so LEAD
  // always lasts exactly HALF_DIV cycles after the accept edge.
  assign div_en  = (state_q != ST_IDLE);
  assign div_clr = (state_q == ST_IDLE);

  spi_sclk_gen #(
    .HALF_DIV (HALF_DIV)
  ) u_sclk_gen (
    .clk   (clk),
    .reset (reset),
    .en    (div_en),
    .clr   (div_clr),
    .tick  (tick)
  );

  assign frame = build_frame(rw, addr, wdata);

  always_comb begin
    state_d   = state_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    rw_d      = rw_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;

    case (state_q)
      ST_IDLE: begin
        sclk_d = 1'b0;
        if (start) begin
          rw_d      = rw;
          shift_d   = frame;
          mosi_d    = frame[FRAME_BITS-1];
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          rx_d      = '0;
          state_d   = ST_LEAD;
        end
      end

      ST_LEAD: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: capture miso for the data half, then present
            // the next bit so mosi is stable across the following rise.
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q >= BIT_CNT_W'(RX_FIRST_FALL)) begin
              rx_d = {rx_q[DATA_W-2:0], miso_pin};
            end
            if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
              state_d = ST_TRAIL;
            end else begin
              shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
              mosi_d  = shift_q[FRAME_BITS-2];
            end
          end
        end
      end

      ST_TRAIL: begin
        if (tick) begin
          state_d = ST_IDLE;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (rw_q == RW_READ) begin
            rdata_d = rx_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        sclk_d  = 1'b0;
        cs_d    = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      rw_q      <= RW_WRITE;
      shift_q   <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      rw_q      <= rw_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign sclk_pin = sclk_q;
  assign cs_pin   = cs_q;
  assign mosi_pin = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Directed self-checking bench: a HALF_DIV=2 master talking to a small
// register-memory slave, plus a HALF_DIV=1 master for back-to-back frames.
// -----------------------------------------------------------------------------
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, sclk_pin, cs_pin, mosi_pin;
  logic [7:0] rdata;
  logic       miso_pin = 1'b0;

  logic       start1 = 1'b0;
  logic       rw1 = 1'b0;
  logic [6:0] addr1 = 7'h2A;
  logic [7:0] wdata1 = 8'h5A;
  logic       busy1, done1, sclk1, cs1, mosi1;
  logic [7:0] rdata1;
  logic       miso1 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master #(.HALF_DIV(2)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .sclk_pin(sclk_pin), .cs_pin(cs_pin),
    .mosi_pin(mosi_pin), .miso_pin(miso_pin)
  );

  spi_master #(.HALF_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .rw(rw1), .addr(addr1), .wdata(wdata1),
    .busy(busy1), .done(done1), .rdata(rdata1), .sclk_pin(sclk1), .cs_pin(cs1),
    .mosi_pin(mosi1), .miso_pin(miso1)
  );

  // Register-memory slave (mode 0), evaluated on the falling clk edge.
  logic [7:0]  mem [0:127];
  logic [15:0] s_frame = '0;
  logic [7:0]  s_byte = '0;
  int          s_cnt = 0;
  logic        s_prev = 1'b0;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
  end

  always @(negedge clk) begin
    if (cs_pin) begin
      s_cnt    = 0;
      s_prev   = 1'b0;
      miso_pin = 1'b0;
    end else begin
      if (sclk_pin && !s_prev) begin
        s_frame = {s_frame[14:0], mosi_pin};
        s_cnt++;
        if (s_cnt == 8 && s_frame[0]) begin
          s_byte   = mem[s_frame[7:1]];
          miso_pin = s_byte[7];
        end
        if (s_cnt == 16 && !s_frame[8]) mem[s_frame[15:9]] = s_frame[7:0];
      end
      if (!sclk_pin && s_prev && s_cnt >= 9) begin
        s_byte   = {s_byte[6:0], 1'b0};
        miso_pin = s_byte[7];
      end
      s_prev = sclk_pin;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cs_pin !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b expected 1", cs_pin); end
    checks++; if (sclk_pin !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk_pin); end
    checks++; if (mosi_pin !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi_pin); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    checks++; if (cs1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_dut1: cs=%b busy=%b expected cs=1 busy=0", cs1, busy1); end
    reset = 1'b0;
    @(negedge clk);
    $display("reset: outputs idle");
  endtask

  // One frame on the HALF_DIV=2 master; optional extra start at edge N+10.
  task automatic test_frame(input string name, input logic f_rw, input logic [6:0] f_addr,
                            input logic [7:0] f_wdata, input bit poke,
                            input logic [15:0] exp_bits, input logic [7:0] exp_rdata);
    logic [15:0] bits = '0;
    int rises = 0, bad_rise = 0, cs_low = 0, done_t = -1, dones = 0;
    logic prev = 1'b0, busy0 = 1'b0, busy_at_done = 1'b1;
    rw = f_rw; addr = f_addr; wdata = f_wdata; start = 1'b1;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (t == 0) begin start = 1'b0; busy0 = busy; end
      if (poke && t == 9) begin start = 1'b1; rw = ~f_rw; addr = 7'h7F; wdata = 8'hFF; end
      if (poke && t == 10) start = 1'b0;
      if (sclk_pin && !prev) begin
        rises++;
        bits = {bits[14:0], mosi_pin};
        if (t != (2 * rises - 1) * 2) bad_rise++;
      end
      prev = sclk_pin;
      if (!cs_pin) cs_low++;
      if (done) begin
        dones++;
        if (done_t < 0) begin done_t = t; busy_at_done = busy; end
      end
    end
    checks++; if (bits !== exp_bits) begin errors++; $display("FAIL %s_bits: got %h expected %h", name, bits, exp_bits); end
    checks++; if (rises != 16) begin errors++; $display("FAIL %s_rises: got %0d expected 16", name, rises); end
    checks++; if (bad_rise != 0) begin errors++; $display("FAIL %s_rise_time: got %0d late/early rises expected 0", name, bad_rise); end
    checks++; if (cs_low != 66) begin errors++; $display("FAIL %s_cs_low: got %0d cycles expected 66", name, cs_low); end
    checks++; if (done_t != 66) begin errors++; $display("FAIL %s_done_time: got N+%0d expected N+66", name, done_t); end
    checks++; if (dones != 1) begin errors++; $display("FAIL %s_done_count: got %0d expected 1", name, dones); end
    checks++; if (busy0 !== 1'b1 || busy_at_done !== 1'b0) begin errors++; $display("FAIL %s_busy: got start=%b done=%b expected 1/0", name, busy0, busy_at_done); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL %s_rdata: got %h expected %h", name, rdata, exp_rdata); end
    $display("%s: rw=%b addr=%h wdata=%h bits=%h done@N+%0d rdata=%h", name, f_rw, f_addr, f_wdata, bits, done_t, rdata);
  endtask

  task automatic test_reset_mid_frame();
    int dones = 0;
    rw = 1'b1; addr = 7'h1D; wdata = 8'h00; start = 1'b1;
    for (int t = 0; t < 21; t++) begin
      @(negedge clk);
      if (t == 0) start = 1'b0;
      if (done) dones++;
      if (t == 19) reset = 1'b1;
    end
    checks++; if (cs_pin !== 1'b1) begin errors++; $display("FAIL abort_cs: got %b expected 1", cs_pin); end
    checks++; if (sclk_pin !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b expected 0", sclk_pin); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL abort_rdata: got %h expected 00", rdata); end
    checks++; if (mosi_pin !== 1'b0) begin errors++; $display("FAIL abort_mosi: got %b expected 0", mosi_pin); end
    reset = 1'b0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (dones != 0 || cs_pin !== 1'b1) begin errors++; $display("FAIL abort_no_done: got %0d dones cs=%b expected 0 dones cs=1", dones, cs_pin); end
    $display("abort: reset at N+20, rdata=%h", rdata);
  endtask

  task automatic test_back_to_back();
    int d [3] = '{0, 0, 0};
    int nd = 0, cs_high = 0;
    start1 = 1'b1;
    for (int t = 0; t < 120; t++) begin
      @(negedge clk);
      if (done1) begin
        if (nd < 3) d[nd] = t;
        nd++;
      end
      if (nd == 1 && cs1) cs_high++;
    end
    start1 = 1'b0;
    checks++; if (nd != 3) begin errors++; $display("FAIL b2b_count: got %0d dones expected 3", nd); end
    checks++; if (d[0] != 33) begin errors++; $display("FAIL b2b_first: got N+%0d expected N+33", d[0]); end
    checks++; if (d[1] - d[0] != 34) begin errors++; $display("FAIL b2b_period1: got %0d expected 34", d[1] - d[0]); end
    checks++; if (d[2] - d[1] != 34) begin errors++; $display("FAIL b2b_period2: got %0d expected 34", d[2] - d[1]); end
    checks++; if (cs_high != 1) begin errors++; $display("FAIL b2b_cs_gap: got %0d cycles expected 1", cs_high); end
    repeat (40) @(negedge clk);
    $display("back_to_back: done at N+%0d, N+%0d, N+%0d, cs gap %0d", d[0], d[1], d[2], cs_high);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame("write_aa", 1'b0, 7'h1D, 8'hAA, 1'b0, 16'h3AAA, 8'h00);
    test_frame("read_aa",  1'b1, 7'h1D, 8'hC3, 1'b0, 16'h3B00, 8'hAA);
    test_frame("write_55", 1'b0, 7'h1D, 8'h55, 1'b0, 16'h3A55, 8'hAA);
    test_frame("read_55",  1'b1, 7'h1D, 8'h00, 1'b0, 16'h3B00, 8'h55);
    test_frame("busy_start", 1'b0, 7'h1D, 8'h33, 1'b1, 16'h3A33, 8'h55);
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
